tx_serial_7o1: RTL and testbench
================================

Name: tx_serial_7o1

Overview:
- Asynchronous serial (UART-style) transmitter for 7-bit ASCII characters.
- Frame format is 7O1: 1 start bit (0), 7 data bits LSB first, 1 odd-parity bit, 1 stop bit (1).
- Runs from the 50 MHz system clock at 115200 baud by default.
- Sits between a character source (partida/dados_ascii handshake) and the serial TX pin; exposes debug taps for board LEDs/displays.

Parameters:
- BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200, truncated).

Ports:
- clock  input  1  system clock, 50 MHz, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- partida  input  1  start request; a rising edge starts one frame.
- dados_ascii  input  7  character to send, bit 0 = LSB.
- saida_serial  output  1  serial line; idle level 1.
- pronto  output  1  one-cycle pulse at end of frame.
- db_partida  output  1  copy of partida.
- db_saida_serial  output  1  copy of saida_serial.
- db_estado  output  4  current FSM state code.

Behaviour:
- Reset (sampled on clock edge while reset=1):
  - FSM goes to INICIAL; saida_serial=1; pronto=0; db_estado=0000.
  - Bit counter, tick counter and edge detector are cleared.
  - Reset mid-frame aborts the frame immediately; the line returns to 1 on the next edge.
- Partida edge detection:
  - partida is registered each cycle; start = partida & ~partida_q.
  - A level held high (e.g. 25 cycles) produces exactly one frame.
  - Start edges are ignored outside INICIAL, including edges during a frame.
- State INICIAL (code 0000):
  - saida_serial=1.
  - On start, go to PREPARACAO.
- State PREPARACAO (code 0001, lasts 1 cycle):
  - Load a 10-bit shift register with {1, p, dados_ascii[6:0], 0}, where p = ~^dados_ascii (odd parity: total ones over data+parity is odd).
  - Clear tick and bit counters; go to TRANSMISSAO.
  - Later changes on dados_ascii do not affect the frame in progress.
- State TRANSMISSAO (code 0010):
  - saida_serial = shift register bit 0.
  - The tick counter counts 0..BAUD_DIV-1. On wrap, shift right (fill with 1) and increment the bit counter.
  - After the 10th bit period completes, go to FINAL.
  - Each bit lasts exactly BAUD_DIV cycles; the frame lasts 10*BAUD_DIV = 4340 cycles.
  - The start bit appears no later than 2 cycles after partida is sampled high.
- State FINAL (code 0011, lasts 1 cycle):
  - pronto=1, saida_serial=1; then go to INICIAL.
  - A new start edge is accepted from the next cycle on.
- Invalid state codes return to INICIAL.
- db_partida = partida and db_saida_serial = saida_serial, combinational copies.
- saida_serial must be driven from a register (glitch-free).

Test Plan:
- Reset, then idle 50 cycles -> saida_serial=1, pronto=0, db_estado=0000 throughout.
- dados_ascii=0110101 ('5'), partida high 25 cycles -> line sequence 0,1,0,1,0,1,1,0,1(parity),1(stop), each bit 434 cycles; one pronto pulse after 4340 cycles.
- dados_ascii=1010101 ('U') -> data bits LSB first 1,0,1,0,1,0,1; parity 1; stop 1; pronto pulses once.
- dados_ascii=1111110 ('~') -> data 0,1,1,1,1,1,1; parity 1. Then dados_ascii=1111111 (DEL) -> data all 1; parity 0.
- Change dados_ascii and pulse partida mid-frame -> the current frame is unchanged and no second frame starts; return to INICIAL after pronto.
- Assert reset during the 4th data bit -> next cycle saida_serial=1, db_estado=0000, no pronto pulse; a later partida edge sends a full correct frame.

Source files
------------

// File: rtl/tx_serial_7o1.sv
`default_nettype none
// ============================================================================
// tx_serial_7o1 : 7O1 UART-style serial transmitter (start, 7 data LSB first,
//                 odd parity, stop). Rev 1.0
// ============================================================================
module tx_serial_7o1 #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados_ascii,
  output logic       saida_serial,
  output logic       pronto,
  output logic       db_partida,
  output logic       db_saida_serial,
  output logic [3:0] db_estado
);

  localparam int                TICK_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_DIV - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    TRANSMISSAO = 4'b0010,
    FINAL       = 4'b0011
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              partida_q;
  logic              start;
  logic              tick_wrap;
  logic              last_bit;
  logic [9:0]        shift_reg;
  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        bit_cnt;

  assign start     = partida & ~partida_q;
  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign last_bit  = (bit_cnt == 4'd9);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INICIAL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pronto     = 1'b0;
    case (state)
      INICIAL:     if (start) state_next = PREPARACAO;
      PREPARACAO:  state_next = TRANSMISSAO;
      TRANSMISSAO: if (tick_wrap && last_bit) state_next = FINAL;
      FINAL: begin
        pronto     = 1'b1;
        state_next = INICIAL;
      end
      default:     state_next = INICIAL;
    endcase
  end

  // The line is bit 0 of the shift register, which idles at all ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      partida_q <= 1'b0;
      shift_reg <= '1;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      partida_q <= partida;
      case (state)
        PREPARACAO: begin
          shift_reg <= {1'b1, ~^dados_ascii, dados_ascii, 1'b0};
          tick_cnt  <= '0;
          bit_cnt   <= '0;
        end
        TRANSMISSAO: begin
          if (tick_wrap) begin
            tick_cnt  <= '0;
            shift_reg <= {1'b1, shift_reg[9:1]};
            bit_cnt   <= bit_cnt + 4'd1;
          end else begin
            tick_cnt  <= tick_cnt + TICK_W'(1);
          end
        end
        default: shift_reg <= '1;
      endcase
    end
  end

  assign saida_serial    = shift_reg[0];
  assign db_partida      = partida;
  assign db_saida_serial = saida_serial;
  assign db_estado       = state;

endmodule
`default_nettype wire

// File: tb/tb_tx_serial_7o1.sv
`default_nettype none
// Directed bench for tx_serial_7o1: reset, idle, several characters,
// mid-frame disturbance and mid-frame reset.
module tb_tx_serial_7o1;

  localparam int BAUD = 434;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       partida = 1'b0;
  logic [6:0] dados_ascii = 7'd0;
  logic       saida_serial;
  logic       pronto;
  logic       db_partida;
  logic       db_saida_serial;
  logic [3:0] db_estado;

  int checks = 0;
  int failures = 0;

  tx_serial_7o1 #(.BAUD_DIV(BAUD)) dut (
    .clock           (clock),
    .reset           (reset),
    .partida         (partida),
    .dados_ascii     (dados_ascii),
    .saida_serial    (saida_serial),
    .pronto          (pronto),
    .db_partida      (db_partida),
    .db_saida_serial (db_saida_serial),
    .db_estado       (db_estado)
  );

  always #10 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (saida_serial !== 1'b1 || pronto !== 1'b0 || db_estado !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: saida=%b pronto=%b estado=%b, required 1 0 0000",
               saida_serial, pronto, db_estado);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    bit bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (saida_serial !== 1'b1 || pronto !== 1'b0 || db_estado !== 4'b0000) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle: saida=%b pronto=%b estado=%b, required 1 0 0000 for 50 cycles",
               saida_serial, pronto, db_estado);
    end
  endtask

  // Sends one character with partida held ~25 cycles and checks every cycle
  // of the frame; optionally changes data and pulses partida mid-frame.
  task automatic run_frame(input logic [6:0] d, input bit disturb, input string name);
    logic [9:0] exp_frame;
    bit         found;
    bit         bad;
    int         cyc;
    exp_frame = {1'b1, ~^d, d, 1'b0};
    @(negedge clock);
    dados_ascii = d;
    partida     = 1'b1;
    found       = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clock);
      if (saida_serial === 1'b0) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s start_latency: saida=%b, required 0 within 2 cycles", name, saida_serial);
    end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < BAUD; c++) begin
        if (b != 0 || c != 0) @(negedge clock);
        cyc = b * BAUD + c;
        if (saida_serial !== exp_frame[b] || pronto !== 1'b0 || db_estado !== 4'b0010 ||
            db_saida_serial !== saida_serial || db_partida !== partida) bad = 1;
        if (cyc == 23) partida = 1'b0;
        if (disturb && cyc == 2000) begin
          dados_ascii = ~d;
          partida     = 1'b1;
        end
        if (disturb && cyc == 2003) partida = 1'b0;
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s bit%0d: saida=%b pronto=%b estado=%b, required line %b for %0d cycles",
                 name, b, saida_serial, pronto, db_estado, exp_frame[b], BAUD);
      end
    end
    @(negedge clock);
    checks++;
    if (pronto !== 1'b1 || db_estado !== 4'b0011 || saida_serial !== 1'b1) begin
      failures++;
      $display("FAIL %s final: pronto=%b estado=%b saida=%b, required 1 0011 1",
               name, pronto, db_estado, saida_serial);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pronto !== 1'b0 || db_estado !== 4'b0000 || saida_serial !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s after_frame: pronto=%b estado=%b saida=%b, required 0 0000 1",
               name, pronto, db_estado, saida_serial);
    end
  endtask

  task automatic test_chars();
    run_frame(7'b0110101, 0, "char_5");
    run_frame(7'b1010101, 0, "char_U");
    run_frame(7'b1111110, 0, "char_tilde");
    run_frame(7'b1111111, 0, "char_del");
  endtask

  task automatic test_midframe_disturb();
    run_frame(7'b1000011, 1, "disturb");
  endtask

  task automatic test_reset_midframe();
    bit bad;
    @(negedge clock);
    dados_ascii = 7'h41;
    partida     = 1'b1;
    repeat (2) @(negedge clock);
    repeat (4 * BAUD + 100) @(negedge clock);
    checks++;
    if (saida_serial !== 1'b0 || db_estado !== 4'b0010) begin
      failures++;
      $display("FAIL rst_mid_pre: saida=%b estado=%b, required 0 0010", saida_serial, db_estado);
    end
    partida = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    checks++;
    if (saida_serial !== 1'b1 || db_estado !== 4'b0000 || pronto !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_abort: saida=%b estado=%b pronto=%b, required 1 0000 0",
               saida_serial, db_estado, pronto);
    end
    reset = 1'b0;
    bad   = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (pronto !== 1'b0 || saida_serial !== 1'b1 || db_estado !== 4'b0000) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rst_mid_quiet: pronto=%b saida=%b estado=%b, required 0 1 0000",
               pronto, saida_serial, db_estado);
    end
    run_frame(7'h41, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_chars();
    test_midframe_disturb();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
